// File: rtl/time_pkg.sv
// Shared types and widths for the stopwatch elapsed/remaining mm:ss counters.
package time_pkg;

  localparam int MMSS_W     = 6;
  localparam int MM_MAX_DEF = 59;
  localparam int SS_MAX_DEF = 59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [MMSS_W-1:0] clamp(input logic [MMSS_W-1:0] v,
                                               input logic [MMSS_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/mmss_decrement.sv
// Combinational mm:ss minus one second, borrowing from minutes; flags an input of 00:01.
module mmss_decrement
  import time_pkg::*;
#(
  parameter int SS_MAX = SS_MAX_DEF
) (
  input  logic [MMSS_W-1:0] mm,
  input  logic [MMSS_W-1:0] ss,
  output logic [MMSS_W-1:0] next_mm,
  output logic [MMSS_W-1:0] next_ss,
  output logic              is_one
);

  always_comb begin
    if (ss != '0) begin
      next_mm = mm;
      next_ss = ss - MMSS_W'(1);
    end else begin
      next_mm = mm - MMSS_W'(1);
      next_ss = MMSS_W'(SS_MAX);
    end
    is_one = (mm == '0) && (ss == MMSS_W'(1));
  end

endmodule

// File: rtl/time_remaining.sv
// Countdown timer: loads a clamped mm:ss preset, decrements per tick, flags expiry.
// Optional TIME_REMAINING_AUTO_RELOAD_EN reloads the preset on expiry instead of stopping.
module time_remaining
  import time_pkg::*;
#(
  parameter int MM_MAX = MM_MAX_DEF,
  parameter int SS_MAX = SS_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              load,
  input  logic [MMSS_W-1:0] load_mm,
  input  logic [MMSS_W-1:0] load_ss,
  input  logic              start,
  input  logic              pause,
  output logic [MMSS_W-1:0] mm,
  output logic [MMSS_W-1:0] ss,
  output logic              running,
  output logic              expired,
  output logic              done
);

  state_t            state, state_n;
  logic [MMSS_W-1:0] preset_mm, preset_ss, preset_mm_n, preset_ss_n;
  logic [MMSS_W-1:0] mm_n, ss_n, dec_mm, dec_ss;
  logic              done_n, is_one;

  mmss_decrement #(.SS_MAX(SS_MAX)) u_dec (
    .mm      (mm),
    .ss      (ss),
    .next_mm (dec_mm),
    .next_ss (dec_ss),
    .is_one  (is_one)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mm        <= '0;
      ss        <= '0;
      preset_mm <= '0;
      preset_ss <= '0;
      running   <= 1'b0;
      expired   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      mm        <= mm_n;
      ss        <= ss_n;
      preset_mm <= preset_mm_n;
      preset_ss <= preset_ss_n;
      running   <= (state_n == RUN);
      expired   <= (state_n == DONE);
      done      <= done_n;
    end
  end

  // Priority chain load > pause > start > tick; a tick only counts when nothing else acts.
  always_comb begin
    state_n     = state;
    mm_n        = mm;
    ss_n        = ss;
    preset_mm_n = preset_mm;
    preset_ss_n = preset_ss;
    done_n      = 1'b0;

    if (load) begin
      preset_mm_n = clamp(load_mm, MMSS_W'(MM_MAX));
      preset_ss_n = clamp(load_ss, MMSS_W'(SS_MAX));
      mm_n        = preset_mm_n;
      ss_n        = preset_ss_n;
      state_n     = IDLE;
    end else if (pause) begin
      if (state == RUN) state_n = PAUSE;
    end else if (start && state != RUN) begin
      case (state)
        IDLE:  if (mm != '0 || ss != '0) state_n = RUN;
        PAUSE: state_n = RUN;
        DONE: begin
          if (preset_mm != '0 || preset_ss != '0) begin
            mm_n    = preset_mm;
            ss_n    = preset_ss;
            state_n = RUN;
          end
        end
        default: state_n = state;
      endcase
    end else if (tick && state == RUN && (mm != '0 || ss != '0)) begin
      if (is_one) begin
        done_n = 1'b1;
`ifdef TIME_REMAINING_AUTO_RELOAD_EN
        mm_n = preset_mm;
        ss_n = preset_ss;
`else
        mm_n    = '0;
        ss_n    = '0;
        state_n = DONE;
`endif
      end else begin
        mm_n = dec_mm;
        ss_n = dec_ss;
      end
    end
  end

endmodule

// File: tb/tb_time_remaining.sv
// Scoreboard bench for time_remaining: stimulus pushes expected mm:ss/flags, a negedge monitor compares.
module tb_time_remaining;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [5:0] load_mm = '0, load_ss = '0;
  logic [5:0] mm, ss;
  logic       running, expired, done;

  int checksTotal  = 0;
  int checksPassed = 0;

  // expected word: {mm, ss, running, expired, done}
  logic [14:0] expQ[$];
  string       nameQ[$];

  time_remaining dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .load    (load),
    .load_mm (load_mm),
    .load_ss (load_ss),
    .start   (start),
    .pause   (pause),
    .mm      (mm),
    .ss      (ss),
    .running (running),
    .expired (expired),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge happen, then return inputs to idle.
  task automatic applyStimulus(input logic ld, input logic [5:0] lmm, input logic [5:0] lss,
                               input logic st, input logic pa, input logic tk);
    load = ld; load_mm = lmm; load_ss = lss; start = st; pause = pa; tick = tk;
    @(posedge clk);
    #1;
    load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int emm, input int ess,
                             input logic erun, input logic eexp, input logic edone);
    expQ.push_back({6'(emm), 6'(ess), erun, eexp, edone});
    nameQ.push_back(name);
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      logic [14:0] e;
      string       n;
      e = expQ.pop_front();
      n = nameQ.pop_front();
      checksTotal++;
      if ({mm, ss, running, expired, done} === e)
        checksPassed++;
      else
        $display("[TB] FAIL %s: got %0d:%0d run=%b exp=%b done=%b, want %0d:%0d run=%b exp=%b done=%b",
                 n, mm, ss, running, expired, done, e[14:9], e[8:3], e[2], e[1], e[0]);
    end
  end

  initial begin
    @(posedge clk);
    #1;
    checkOutput("reset_state", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("start_at_zero_ignored", 0, 0, 0, 0, 0);

    applyStimulus(1, 1, 2, 0, 0, 0);
    checkOutput("load_0102", 1, 2, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("idle_tick_ignored", 1, 2, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("start_0102", 1, 2, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("tick1_0101", 1, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("tick2_0100", 1, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("tick3_borrow_0059", 0, 59, 1, 0, 0);

    applyStimulus(1, 63, 63, 0, 0, 0);
    checkOutput("clamp_5959", 59, 59, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("start_5959", 59, 59, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("tick_5958", 59, 58, 1, 0, 0);
    applyStimulus(1, 0, 5, 0, 0, 1);
    checkOutput("abort_load_0005", 0, 5, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("abort_idle_hold", 0, 5, 0, 0, 0);

    applyStimulus(1, 0, 31, 0, 0, 0);
    checkOutput("load_0031", 0, 31, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("start_0031", 0, 31, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("tick_0030", 0, 30, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("pause_drops_tick", 0, 30, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("paused_hold", 0, 30, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 1, 0, 1);
    checkOutput("resume_drops_tick", 0, 30, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("resumed_0029", 0, 29, 1, 0, 0);

`ifdef TIME_REMAINING_AUTO_RELOAD_EN
    applyStimulus(1, 0, 2, 0, 0, 0);
    checkOutput("ar_load_0002", 0, 2, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("ar_start", 0, 2, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("ar_tick1", 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("ar_tick2_reload", 0, 2, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("ar_tick3", 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("ar_tick4_reload", 0, 2, 1, 0, 1);
`else
    applyStimulus(1, 0, 2, 0, 0, 0);
    checkOutput("load_0002", 0, 2, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("start_0002", 0, 2, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("tick_0001", 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("expire_done", 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("done_one_clk", 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("no_underflow", 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("done_pause_ignored", 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 1);
    checkOutput("done_restart_preset", 0, 2, 1, 0, 0);
`endif

    applyStimulus(1, 3, 10, 0, 0, 0);
    checkOutput("load_0310", 3, 10, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("start_0310", 3, 10, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    checkOutput("async_reset_mid_run", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("preset_lost_after_reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() > 0) begin
      checksTotal++;
      $display("[TB] FAIL drain_timeout: got %0d pending, want 0", expQ.size());
    end
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
